// File: rtl/uart_buffer_sequencer.sv
// -----------------------------------------------------------------------------
// uart_buffer_sequencer
//
// Purpose:
//   Walks the UART handler's byte RAM once per pass, rewriting each byte in
//   place with a selectable operation and accumulating a checksum of the
//   original bytes. When the last byte is written, it kicks the handler's
//   transmitter. It then waits for the handler to take ownership of the RAM
//   before it returns to idle.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   enable         allows a new pass to start from IDLE
//   mode[1:0]      0 pass-through, 1 XOR key, 2 add key mod 256, 3 invert
//   key[7:0]       operand for modes 1 and 2 (latched at pass start)
//   handler_ready  the handler is idle and the RAM belongs to this block
//   handler_start  one-cycle pulse that starts handler transmission
//   ram_addr       RAM address (read data returns one cycle later)
//   ram_we         RAM write enable (WRITE state only)
//   ram_wdata      RAM write data
//   ram_rdata      RAM read data
//   busy           high from pass start until handler_start is issued
//   done           pulse when the handler takes the RAM after a pass
//   error          pulse when a pass is aborted because ready dropped
//   checksum[7:0]  sum mod 256 of the original bytes of the last pass
// -----------------------------------------------------------------------------
module uart_buffer_sequencer #(
  parameter int RAM_SIZE  = 64,
  parameter int ADDR_BITS = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic [7:0]           key,
  input  logic                 handler_ready,
  output logic                 handler_start,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic                 ram_we,
  output logic [7:0]           ram_wdata,
  input  logic [7:0]           ram_rdata,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [7:0]           checksum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_KICK,
    S_RELEASE
  } state_t;

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(RAM_SIZE - 1);

  state_t               state, state_next;
  logic [ADDR_BITS-1:0] addr;
  logic [1:0]           mode_q;
  logic [7:0]           key_q;

  logic pass_start;
  logic write_ok;

  function automatic logic [7:0] apply_op(input logic [1:0] op,
                                          input logic [7:0] k,
                                          input logic [7:0] b);
    case (op)
      2'd1:    apply_op = b ^ k;
      2'd2:    apply_op = b + k;   // 8-bit result wraps mod 256
      2'd3:    apply_op = ~b;
      default: apply_op = b;
    endcase
  endfunction

  assign pass_start = (state == S_IDLE) && handler_ready && enable;
  // A write only lands while the handler still lets us own the RAM.
  assign write_ok   = (state == S_WRITE) && handler_ready;

  // NOTE: sequential state uses non-blocking (<=) assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      addr     <= '0;
      checksum <= '0;
      mode_q   <= '0;
      key_q    <= '0;
    end else begin
      state <= state_next;
      if (pass_start) begin
        mode_q   <= mode;
        key_q    <= key;
        addr     <= '0;
        checksum <= '0;
      end else if (write_ok) begin
        checksum <= checksum + ram_rdata;
        // Hold at the last address so addr never exceeds RAM_SIZE-1.
        if (addr != LAST_ADDR) addr <= addr + 1'b1;
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next    = state;
    handler_start = 1'b0;
    ram_addr      = '0;
    ram_we        = 1'b0;
    ram_wdata     = '0;
    busy          = 1'b0;
    done          = 1'b0;
    error         = 1'b0;

    case (state)
      S_IDLE: begin
        if (pass_start) state_next = S_READ;
      end
      S_READ: begin
        busy     = 1'b1;
        ram_addr = addr;
        if (!handler_ready) begin
          error      = 1'b1;
          state_next = S_IDLE;
        end else begin
          state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        busy      = 1'b1;
        ram_addr  = addr;
        ram_wdata = apply_op(mode_q, key_q, ram_rdata);
        if (!handler_ready) begin
          error      = 1'b1;
          state_next = S_IDLE;
        end else begin
          ram_we     = 1'b1;
          state_next = (addr == LAST_ADDR) ? S_KICK : S_READ;
        end
      end
      S_KICK: begin
        busy          = 1'b1;
        handler_start = 1'b1;
        state_next    = S_RELEASE;
      end
      S_RELEASE: begin
        // Leave only once ready falls, so a stale ready level cannot
        // immediately start another pass.
        if (!handler_ready) begin
          done       = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase

    // A reset cycle must not write the RAM or emit any event pulse.
    if (reset) begin
      ram_we        = 1'b0;
      handler_start = 1'b0;
      done          = 1'b0;
      error         = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_buffer_sequencer.sv
module tb_uart_buffer_sequencer;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [1:0] mode;
  logic [7:0] key;
  logic       handler_ready;
  logic       handler_start;
  logic [1:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] checksum;

  uart_buffer_sequencer #(.RAM_SIZE(N), .ADDR_BITS(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .key(key),
    .handler_ready(handler_ready), .handler_start(handler_start),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy), .done(done), .error(error),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  // Handler RAM: registered read, written by the DUT or preloaded by the bench.
  logic [7:0] mem [N];
  logic [7:0] preload [N];
  logic       do_load = 1'b0;

  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    if (do_load) begin
      for (int i = 0; i < N; i++) mem[i] <= preload[i];
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int start_cnt = 0, done_cnt = 0, err_cnt = 0, start_cyc = 0;
  always @(negedge clk) begin
    if (handler_start) begin start_cnt++; start_cyc = cyc; end
    if (done)  done_cnt++;
    if (error) err_cnt++;
  end

  int passed = 0;
  int total  = 0;

  // Reference byte operation, straight from the mode table.
  function automatic logic [7:0] ref_op(input int m, input int k, input int b);
    case (m)
      1:       ref_op = 8'(b ^ k);
      2:       ref_op = 8'((b + k) % 256);
      3:       ref_op = 8'(255 - b);
      default: ref_op = 8'(b);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] d [N]);
    for (int i = 0; i < N; i++) preload[i] = d[i];
    do_load = 1'b1;
    step();
    do_load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; handler_ready = 1'b1; mode = 2'd0; key = 8'h00;
    step(); step();
    total++;
    if ({handler_start, ram_we, busy, done, error} !== 5'b0) begin
      $display("FAIL reset_outputs: got %b want 00000",
               {handler_start, ram_we, busy, done, error});
    end else passed++;
    total++;
    if (checksum !== 8'h00) $display("FAIL reset_checksum: got %h want 00", checksum);
    else passed++;
    total++;
    if (ram_addr !== 2'd0 || ram_wdata !== 8'h00)
      $display("FAIL reset_ram_bus: addr %0d wdata %h want 0 0", ram_addr, ram_wdata);
    else passed++;
    reset = 1'b0;
    step(); step();
    total++;
    if (busy !== 1'b0) $display("FAIL idle_without_enable: busy %b want 0", busy);
    else passed++;
  endtask

  // One full pass; optionally changes mode/key mid-pass.
  task automatic run_pass(input string name, input logic [7:0] d [N],
                          input int m, input int k, input bit change_mid);
    int e, s0, d0, e0, exp_sum, bad;
    logic [7:0] exp_mem [N];
    exp_sum = 0;
    for (int i = 0; i < N; i++) begin
      exp_mem[i] = ref_op(m, k, int'(d[i]));
      exp_sum   += int'(d[i]);
    end
    exp_sum = exp_sum % 256;
    load(d);
    s0 = start_cnt; d0 = done_cnt; e0 = err_cnt;
    mode = 2'(m); key = 8'(k); handler_ready = 1'b1; enable = 1'b1;
    step();
    e = cyc;
    enable = 1'b0;
    if (change_mid) begin mode = 2'(m ^ 2); key = 8'($urandom_range(255)); end
    total++;
    if (busy !== 1'b1) $display("FAIL %s_busy: got %b want 1", name, busy);
    else passed++;
    for (int i = 0; i < 40 && !handler_start; i++) step();
    total++;
    if (!handler_start) $display("FAIL %s_start_timeout: got 0 want 1", name);
    else if (cyc - e != 2 * N)
      $display("FAIL %s_start_latency: got %0d want %0d", name, cyc - e, 2 * N);
    else passed++;
    step();
    // Stale ready with enable high must neither restart nor finish.
    enable = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (busy !== 1'b0 || done !== 1'b0) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL %s_retrigger: %0d bad cycles want 0", name, bad);
    else passed++;
    handler_ready = 1'b0;
    #1;
    total++;
    if (done !== 1'b1) $display("FAIL %s_done_on_fall: got %b want 1", name, done);
    else passed++;
    step();
    enable = 1'b0;
    step();
    bad = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== exp_mem[i]) bad++;
    total++;
    if (bad != 0)
      $display("FAIL %s_ram: got %h %h %h %h want %h %h %h %h", name,
               mem[0], mem[1], mem[2], mem[3],
               exp_mem[0], exp_mem[1], exp_mem[2], exp_mem[3]);
    else passed++;
    total++;
    if (checksum !== 8'(exp_sum))
      $display("FAIL %s_checksum: got %h want %h", name, checksum, 8'(exp_sum));
    else passed++;
    total++;
    if (start_cnt - s0 != 1 || done_cnt - d0 != 1 || err_cnt - e0 != 0)
      $display("FAIL %s_pulses: start %0d done %0d err %0d want 1 1 0", name,
               start_cnt - s0, done_cnt - d0, err_cnt - e0);
    else passed++;
  endtask

  task automatic test_mode1_pass();
    logic [7:0] d [N];
    d = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_pass("mode1", d, 1, 8'hFF, 1'b0);
  endtask

  task automatic test_mode2_wrap();
    logic [7:0] d [N];
    d = '{8'hFF, 8'h80, 8'h00, 8'h01};
    run_pass("mode2_wrap", d, 2, 8'h02, 1'b0);
  endtask

  task automatic test_mode_change();
    logic [7:0] d [N];
    for (int i = 0; i < N; i++) d[i] = 8'($urandom_range(255));
    run_pass("mode_change", d, 1, int'($urandom_range(255)), 1'b1);
  endtask

  task automatic test_random_passes();
    logic [7:0] d [N];
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < N; i++) d[i] = 8'($urandom_range(255));
      run_pass("random", d, int'($urandom_range(3)), int'($urandom_range(255)),
               p[0]);
    end
  endtask

  task automatic test_abort();
    logic [7:0] d [N];
    int s0, e0, bad;
    for (int i = 0; i < N; i++) d[i] = 8'($urandom_range(255));
    load(d);
    s0 = start_cnt; e0 = err_cnt;
    mode = 2'd3; key = 8'h00; handler_ready = 1'b1; enable = 1'b1;
    step();              // READ byte 0
    enable = 1'b0;
    step(); step(); step(); step();   // now READ byte 2
    handler_ready = 1'b0;
    #1;
    total++;
    if (error !== 1'b1 || ram_we !== 1'b0)
      $display("FAIL abort_pulse: error %b we %b want 1 0", error, ram_we);
    else passed++;
    step();
    total++;
    if (busy !== 1'b0) $display("FAIL abort_idle: busy %b want 0", busy);
    else passed++;
    step(); step();
    bad = 0;
    if (mem[0] !== ref_op(3, 0, int'(d[0]))) bad++;
    if (mem[1] !== ref_op(3, 0, int'(d[1]))) bad++;
    if (mem[2] !== d[2]) bad++;
    if (mem[3] !== d[3]) bad++;
    total++;
    if (bad != 0)
      $display("FAIL abort_ram: got %h %h %h %h, %0d bytes wrong", mem[0], mem[1],
               mem[2], mem[3], bad);
    else passed++;
    total++;
    if (err_cnt - e0 != 1 || start_cnt - s0 != 0)
      $display("FAIL abort_pulses: err %0d start %0d want 1 0", err_cnt - e0,
               start_cnt - s0);
    else passed++;
  endtask

  task automatic test_reset_mid_pass();
    logic [7:0] d [N];
    int d0, e0;
    for (int i = 0; i < N; i++) d[i] = 8'($urandom_range(255));
    load(d);
    d0 = done_cnt; e0 = err_cnt;
    mode = 2'd3; key = 8'h00; handler_ready = 1'b1; enable = 1'b1;
    step();              // READ byte 0
    enable = 1'b0;
    step(); step(); step();           // now WRITE byte 1
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++;
    if ({handler_start, ram_we, busy, done, error} !== 5'b0 || checksum !== 8'h00
        || ram_addr !== 2'd0 || ram_wdata !== 8'h00)
      $display("FAIL midreset_outputs: flags %b sum %h addr %0d wdata %h want 0",
               {handler_start, ram_we, busy, done, error}, checksum, ram_addr,
               ram_wdata);
    else passed++;
    step(); step();
    total++;
    if (mem[0] !== ref_op(3, 0, int'(d[0])) || mem[1] !== d[1])
      $display("FAIL midreset_ram: got %h %h want %h %h", mem[0], mem[1],
               ref_op(3, 0, int'(d[0])), d[1]);
    else passed++;
    total++;
    if (done_cnt != d0 || err_cnt != e0)
      $display("FAIL midreset_pulses: done %0d err %0d want 0 0", done_cnt - d0,
               err_cnt - e0);
    else passed++;
    handler_ready = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_mode1_pass();
    test_mode2_wrap();
    test_mode_change();
    test_random_passes();
    test_abort();
    test_reset_mid_pass();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
